// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder - fetch-side slave: fixed-latency program RAM read, FWFT
// response FIFO with flush, and a side port for loading program images.
// Revision 1.0
// ============================================================================
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_req_valid,
  output logic                           o_req_ready,
  input  logic [31:0]                    i_req_addr,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [31:0]                    o_rsp_inst,
  output logic                           o_rsp_fault,
  input  logic                           i_flush,
  input  logic                           i_load_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_load_addr,
  input  logic [31:0]                    i_load_data
);
  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  logic [31:0]           ram_q [DEPTH_WORDS];
  logic [31:0]           fifo_inst_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_fault_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic        accept, acc_fault, rsp_xfer;
  logic [31:0] acc_inst;
  logic        push_valid, push_fault;
  logic [31:0] push_inst;

  assign o_req_ready = i_rst_n && !i_load_en && !i_flush && (count_q < CNT_W'(FIFO_DEPTH));
  assign accept      = i_req_valid && o_req_ready;
  assign acc_fault   = (i_req_addr[1:0] != 2'b00) || (i_req_addr[31:RAM_AW+2] != '0);
  assign acc_inst    = acc_fault ? 32'h0 : ram_q[i_req_addr[RAM_AW+1:2]];

  // The RAM read happens at the acceptance edge; LATENCY-1 further stages
  // carry it so the FIFO entry becomes visible LATENCY cycles after acceptance.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_valid = accept;
      assign push_fault = acc_fault;
      assign push_inst  = acc_inst;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q, vld_d, flt_q, flt_d;
      logic [31:0]        inst_q [LATENCY-1];
      logic [31:0]        inst_d [LATENCY-1];

      always_comb begin
        vld_d     = '0;
        flt_d     = '0;
        inst_d    = inst_q;
        vld_d[0]  = accept;
        flt_d[0]  = acc_fault;
        inst_d[0] = acc_inst;
        for (int k = 1; k < LATENCY - 1; k++) begin
          vld_d[k]  = vld_q[k-1];
          flt_d[k]  = flt_q[k-1];
          inst_d[k] = inst_q[k-1];
        end
        if (i_flush) vld_d = '0;
      end

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) vld_q <= '0;
        else          vld_q <= vld_d;
        flt_q  <= flt_d;
        inst_q <= inst_d;
      end

      assign push_valid = vld_q[LATENCY-2];
      assign push_fault = flt_q[LATENCY-2];
      assign push_inst  = inst_q[LATENCY-2];
    end
  endgenerate

  assign o_rsp_valid = (wr_ptr_q != rd_ptr_q);
  assign o_rsp_inst  = o_rsp_valid ? fifo_inst_q[rd_ptr_q[PTR_W-1:0]] : 32'h0;
  assign o_rsp_fault = o_rsp_valid && fifo_fault_q[rd_ptr_q[PTR_W-1:0]];
  assign rsp_xfer    = o_rsp_valid && i_rsp_ready && !i_flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_valid) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rsp_xfer)   rd_ptr_d = rd_ptr_q + 1'b1;
      case ({accept, rsp_xfer})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage arrays carry no reset; validity lives in the pointers.
  always_ff @(posedge i_clk) begin
    if (push_valid && !i_flush) begin
      fifo_inst_q[wr_ptr_q[PTR_W-1:0]]  <= push_inst;
      fifo_fault_q[wr_ptr_q[PTR_W-1:0]] <= push_fault;
    end
    if (i_load_en) ram_q[i_load_addr] <= i_load_data;
  end

endmodule
`default_nettype wire
